timer_count_core: RTL and testbench

TIMER_COUNT_CORE -- requirements
Module: timer_count_core

---
 rtl/timer_count_core_pkg.sv | 24 ++
 rtl/timer_count_core.sv | 70 +++++++
 tb/tb_timer_count_core.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/timer_count_core_pkg.sv
// Shared timer definitions: counter geometry, reset values and a half-word load helper.
package timer_count_core_pkg;

  localparam int unsigned CNT_W  = 64;
  localparam int unsigned HALF_W = 32;

  localparam logic [CNT_W-1:0] CNT_RST_VAL = 64'h0000_0000_0000_0000;
  localparam logic [CNT_W-1:0] CMP_RST_VAL = 64'hFFFF_FFFF_FFFF_FFFF;

  // Replace the strobed 32-bit halves of cur with data; unselected halves hold.
  function automatic logic [CNT_W-1:0] load_halves(
    input logic [CNT_W-1:0]  cur,
    input logic [HALF_W-1:0] data,
    input logic              lo,
    input logic              hi
  );
    logic [CNT_W-1:0] res;
    res = cur;
    if (lo) res[HALF_W-1:0]     = data;
    if (hi) res[CNT_W-1:HALF_W] = data;
    return res;
  endfunction

endpackage

// File: rtl/timer_count_core.sv
// 64-bit free-running timer counter with compare register and sticky match interrupt.
module timer_count_core
  import timer_count_core_pkg::*;
(
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              count_en,
  input  logic              timer_en,
  input  logic [HALF_W-1:0] wdata,
  input  logic              wr_cnt_lo,
  input  logic              wr_cnt_hi,
  input  logic              wr_cmp_lo,
  input  logic              wr_cmp_hi,
  input  logic              int_en,
  input  logic              int_st_clr,
  output logic [CNT_W-1:0]  cnt,
  output logic [CNT_W-1:0]  cmp,
  output logic              int_st,
  output logic              tim_int
);

  logic             timer_en_q;
  logic             match;
  logic             disable_edge;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cmp_d;
  logic             int_st_d;

  assign match        = (cnt == cmp);
  assign disable_edge = timer_en_q & ~timer_en;
  assign tim_int      = int_st & int_en;

  // Next-state: writes beat clear-on-disable, which beats increment; match set beats clear.
  always_comb begin
    cnt_d    = cnt;
    cmp_d    = cmp;
    int_st_d = int_st;

    if (wr_cnt_lo || wr_cnt_hi) begin
      cnt_d = load_halves(cnt, wdata, wr_cnt_lo, wr_cnt_hi);
    end else if (disable_edge) begin
      cnt_d = CNT_RST_VAL;
    end else if (count_en) begin
      cnt_d = cnt + CNT_W'(1);
    end

    cmp_d = load_halves(cmp, wdata, wr_cmp_lo, wr_cmp_hi);

    if (match) begin
      int_st_d = 1'b1;
    end else if (int_st_clr) begin
      int_st_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt        <= CNT_RST_VAL;
      cmp        <= CMP_RST_VAL;
      int_st     <= 1'b0;
      timer_en_q <= 1'b0;
    end else begin
      cnt        <= cnt_d;
      cmp        <= cmp_d;
      int_st     <= int_st_d;
      timer_en_q <= timer_en;
    end
  end

endmodule

// File: tb/tb_timer_count_core.sv
// Randomized bench for timer_count_core: arithmetic reference model, per-cycle compare, directed anchors.
module tb_timer_count_core;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        count_en = 1'b0;
  logic        timer_en = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic        wr_cnt_lo = 1'b0;
  logic        wr_cnt_hi = 1'b0;
  logic        wr_cmp_lo = 1'b0;
  logic        wr_cmp_hi = 1'b0;
  logic        int_en = 1'b0;
  logic        int_st_clr = 1'b0;
  logic [63:0] cnt;
  logic [63:0] cmp;
  logic        int_st;
  logic        tim_int;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  // Reference state
  logic [63:0] m_cnt = 64'h0;
  logic [63:0] m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
  logic        m_st  = 1'b0;
  logic        m_ten = 1'b0;
  logic [63:0] n_cnt, n_cmp_v;
  logic        n_st;

  timer_count_core dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .count_en  (count_en),
    .timer_en  (timer_en),
    .wdata     (wdata),
    .wr_cnt_lo (wr_cnt_lo),
    .wr_cnt_hi (wr_cnt_hi),
    .wr_cmp_lo (wr_cmp_lo),
    .wr_cmp_hi (wr_cmp_hi),
    .int_en    (int_en),
    .int_st_clr(int_st_clr),
    .cnt       (cnt),
    .cmp       (cmp),
    .int_st    (int_st),
    .tim_int   (tim_int)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: what the registers must hold after each edge
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_cnt = 64'h0;
      m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
      m_st  = 1'b0;
      m_ten = 1'b0;
    end else begin
      n_cnt = m_cnt;
      if (wr_cnt_lo || wr_cnt_hi) begin
        if (wr_cnt_lo) n_cnt[31:0]  = wdata;
        if (wr_cnt_hi) n_cnt[63:32] = wdata;
      end else if (m_ten && !timer_en) begin
        n_cnt = 64'h0;
      end else if (count_en) begin
        n_cnt = m_cnt + 64'd1;
      end
      n_cmp_v = m_cmp;
      if (wr_cmp_lo) n_cmp_v[31:0]  = wdata;
      if (wr_cmp_hi) n_cmp_v[63:32] = wdata;
      if (m_cnt == m_cmp)  n_st = 1'b1;
      else if (int_st_clr) n_st = 1'b0;
      else                 n_st = m_st;
      m_cnt = n_cnt;
      m_cmp = n_cmp_v;
      m_st  = n_st;
      m_ten = timer_en;
    end
  end

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge sys_clk) begin
    if (chk_on) begin
      check64("cnt_vs_model", cnt, m_cnt);
      check64("cmp_vs_model", cmp, m_cmp);
      check64("int_st_vs_model", {63'h0, int_st}, {63'h0, m_st});
      check64("tim_int_vs_model", {63'h0, tim_int}, {63'h0, m_st & int_en});
    end
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
    wr_cnt_lo  = 1'b0;
    wr_cnt_hi  = 1'b0;
    wr_cmp_lo  = 1'b0;
    wr_cmp_hi  = 1'b0;
    int_st_clr = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #1 sys_rst_n = 1'b0;
    chk_on = 1'b1;
    steps(3);
    check64("reset_cnt", cnt, 64'h0);
    check64("reset_cmp", cmp, 64'hFFFF_FFFF_FFFF_FFFF);
    check64("reset_int_st", {63'h0, int_st}, 64'h0);
    check64("reset_tim_int", {63'h0, tim_int}, 64'h0);
    sys_rst_n = 1'b1;
    step();

    // Count five cycles
    timer_en = 1'b1;
    count_en = 1'b1;
    steps(5);
    count_en = 1'b0;
    check64("count5_cnt", cnt, 64'h5);
    check64("count5_int_st", {63'h0, int_st}, 64'h0);

    // Move cmp away from all-ones so the wrap test cannot match
    wdata = 32'h10; wr_cmp_lo = 1'b1; step();
    wdata = 32'h0;  wr_cmp_hi = 1'b1; step();
    check64("cmp_loaded", cmp, 64'h10);

    // Half write keeps the other half, then simultaneous halves, then wrap
    wdata = 32'hFFFF_FFFF; wr_cnt_hi = 1'b1; step();
    check64("hi_write_holds_lo", cnt, 64'hFFFF_FFFF_0000_0005);
    wdata = 32'hFFFF_FFFF; wr_cnt_lo = 1'b1; wr_cnt_hi = 1'b1; step();
    check64("both_halves", cnt, 64'hFFFF_FFFF_FFFF_FFFF);
    count_en = 1'b1; step(); count_en = 1'b0;
    check64("wrap_cnt", cnt, 64'h0);
    check64("wrap_int_st", {63'h0, int_st}, 64'h0);

    // Count up to cmp = 0x10 with interrupts masked
    int_en = 1'b0;
    count_en = 1'b1; steps(16); count_en = 1'b0;
    check64("at_cmp_cnt", cnt, 64'h10);
    check64("at_cmp_int_st_not_yet", {63'h0, int_st}, 64'h0);
    step();
    check64("match_int_st", {63'h0, int_st}, 64'h1);
    check64("masked_tim_int", {63'h0, tim_int}, 64'h0);
    int_en = 1'b1; #1;
    check64("unmasked_tim_int", {63'h0, tim_int}, 64'h1);

    // Clear loses against a live match, succeeds once cnt moves on
    int_st_clr = 1'b1; step();
    check64("clr_during_match", {63'h0, int_st}, 64'h1);
    count_en = 1'b1; step(); count_en = 1'b0;
    check64("moved_off_cmp", cnt, 64'h11);
    int_st_clr = 1'b1; step();
    check64("clr_after_move", {63'h0, int_st}, 64'h0);
    check64("clr_tim_int", {63'h0, tim_int}, 64'h0);

    // Disable edge clears cnt even with count_en
    wdata = 32'h1234; wr_cnt_lo = 1'b1; step();
    check64("load_1234", cnt, 64'h1234);
    timer_en = 1'b0; count_en = 1'b1; step(); count_en = 1'b0;
    check64("disable_clear", cnt, 64'h0);
    timer_en = 1'b1; step();
    wdata = 32'h1234; wr_cnt_lo = 1'b1; step();
    timer_en = 1'b0; count_en = 1'b1; wdata = 32'h55; wr_cnt_lo = 1'b1; step();
    count_en = 1'b0;
    check64("write_beats_disable", cnt, 64'h55);
    timer_en = 1'b1; step();

    // Asynchronous reset mid-count, observed before any clock edge
    count_en = 1'b1; steps(3);
    #2 sys_rst_n = 1'b0;
    #1;
    check64("async_rst_cnt", cnt, 64'h0);
    check64("async_rst_cmp", cmp, 64'hFFFF_FFFF_FFFF_FFFF);
    check64("async_rst_int_st", {63'h0, int_st}, 64'h0);
    count_en = 1'b0;
    steps(2);
    sys_rst_n = 1'b1;
    step();
    check64("post_rst_hold", cnt, 64'h0);

    // Randomized traffic; small values keep matches frequent
    timer_en = 1'b1;
    wdata = 32'h20; wr_cmp_lo = 1'b1; wr_cmp_hi = 1'b0; step();
    wdata = 32'h0;  wr_cmp_hi = 1'b1; step();
    for (int i = 0; i < 4000; i++) begin
      count_en   = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 99) < 3) timer_en = ~timer_en;
      if ($urandom_range(0, 99) < 10) int_en = ~int_en;
      int_st_clr = ($urandom_range(0, 99) < 20);
      case ($urandom_range(0, 3))
        0: wdata = $urandom;
        1: wdata = 32'hFFFF_FFFF;
        default: wdata = $urandom_range(0, 48);
      endcase
      if ($urandom_range(0, 99) < 4) wr_cnt_lo = 1'b1;
      if ($urandom_range(0, 99) < 2) wr_cnt_hi = 1'b1;
      if ($urandom_range(0, 99) < 2) wr_cmp_lo = 1'b1;
      if ($urandom_range(0, 99) < 1) wr_cmp_hi = 1'b1;
      if (wr_cnt_hi || wr_cmp_hi) begin
        if ($urandom_range(0, 1) == 1) wdata = 32'h0;
      end
      if (i % 1000 == 777) begin
        #2 sys_rst_n = 1'b0;
        #3 sys_rst_n = 1'b1;
      end
      step();
    end

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
